iir: RTL and testbench

IIR -- requirements
Module: iir

---
 rtl/iir.sv | 75 +++++++
 tb/tb_iir.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/iir.sv
`default_nettype none
// ============================================================================
// Module      : iir
// Description : Second-order recursive filter with fixed coefficients
//               a1 = +1/2, a2 = -1/4:
//                   y[n] = sat(round(x[n] + y[n-1]/2 - y[n-2]/4))
//               Samples are signed Q1.10. The input is registered first,
//               then the new output is formed combinationally from the
//               registered input and the two output history registers.
//               Total latency from input to output is two rising edges.
// Ports       : clk - system clock, rising-edge active
//               rst - asynchronous active-high reset, clears all history
//               x   - input sample, signed Q1.10
//               z   - filtered sample, signed Q1.10, straight from a register
// Revision    : 1.0 - initial release
// ============================================================================
module iir (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    output logic [10:0] z
);

    localparam logic signed [13:0] C_MAX   = 14'sd1023;
    localparam logic signed [13:0] C_MIN   = -14'sd1024;
    localparam logic signed [13:0] C_ROUND = 14'sd2;

    logic signed [10:0] r_x;
    logic signed [10:0] r_y1;
    logic signed [10:0] r_y2;

    logic signed [13:0] w_x_ext;
    logic signed [13:0] w_y1_ext;
    logic signed [13:0] w_y2_ext;
    logic signed [13:0] w_acc;
    logic signed [13:0] w_rnd;
    logic signed [10:0] w_sat;

    // Sign-extend everything to the accumulator width before adding.
    assign w_x_ext  = {{3{r_x[10]}},  r_x};
    assign w_y1_ext = {{3{r_y1[10]}}, r_y1};
    assign w_y2_ext = {{3{r_y2[10]}}, r_y2};

    // Accumulator in units of 2^-12: 4*x + 2*y1 - y2. Its magnitude stays
    // below 7168, so 14 signed bits cannot overflow for any input.
    assign w_acc = (w_x_ext <<< 2) + (w_y1_ext <<< 1) - w_y2_ext;

    // Add half an LSB then floor: rounds ties toward +infinity.
    assign w_rnd = (w_acc + C_ROUND) >>> 2;

    always_comb begin
        w_sat = w_rnd[10:0];
        if (w_rnd > C_MAX) begin
            w_sat = 11'sh3FF;
        end else if (w_rnd < C_MIN) begin
            w_sat = 11'sh400;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= '0;
            r_y1 <= '0;
            r_y2 <= '0;
        end else begin
            r_x  <= x;
            r_y1 <= w_sat;
            r_y2 <= r_y1;
        end
    end

    assign z = r_y1;

endmodule
`default_nettype wire

// File: tb/tb_iir.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir
// Description : Self-checking bench for iir. A sample-level reference model
//               keeps the output history and evaluates the difference
//               equation with integer floor division and clamping; a
//               compare process checks z against it on every falling edge.
//               Directed sequences carry hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir;

    logic               clk;
    logic               rst;
    logic signed [10:0] x;
    logic signed [10:0] z;

    int total;
    int bad;

    // Reference model state: registered input and output history.
    int m_xr;
    int m_yq[$];

    iir dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_next(int xr, int y1, int y2);
        int num;
        int q;
        num = 4 * xr + 2 * y1 - y2 + 2;
        q   = num / 4;
        if (num < 0 && (num % 4) != 0) q = q - 1;   // floor, not truncate
        if (q > 1023)  q = 1023;
        if (q < -1024) q = -1024;
        return q;
    endfunction

    function automatic int hist(int back);
        if (m_yq.size() > back) return m_yq[m_yq.size() - 1 - back];
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_yq.delete();
            m_xr = 0;
        end else begin
            m_yq.push_back(model_next(m_xr, hist(0), hist(1)));
            m_xr = int'(x);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model", int'(z), hist(0));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        x   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_impulse(input string tag);
        int imp[13];
        imp = '{0, 1023, 512, 0, -128, -64, 0, 16, 8, 0, -2, -1, 0};
        x = 11'sd1023;
        for (int i = 0; i < 13; i++) begin
            tick();
            x = '0;
            chk(tag, int'(z), imp[i]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        x     = '0;
        #1;
        chk("reset_async", int'(z), 0);
        do_reset();
        chk("reset_z", int'(z), 0);

        // Zero input for 100 edges
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("zero", int'(z), 0);
        end

        // Impulse, then let it decay
        do_reset();
        do_impulse("impulse");
        repeat (90) tick();

        // Mid-run reset during decay, then repeat the impulse
        do_reset();
        x = 11'sd1023;
        tick();
        x = '0;
        repeat (4) tick();
        chk("pre_reset", int'(z), -128);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", int'(z), 0);
        tick();
        tick();
        rst = 1'b0;
        do_impulse("impulse2");
        repeat (10) tick();

        // Positive step held by saturation
        do_reset();
        x = 11'sd1023;
        tick();
        chk("pos_step0", int'(z), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("pos_step", int'(z), 1023);
        end

        // Negative step held by saturation
        do_reset();
        x = -11'sd1024;
        tick();
        chk("neg_step0", int'(z), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("neg_step", int'(z), -1024);
        end

        // Rounding: y1=0, y2=1, x_r=0 -> acc=-1 -> 0
        do_reset();
        x = 11'sd1;   tick(); chk("rnd_a0", int'(z), 0);
        x = -11'sd1;  tick(); chk("rnd_a1", int'(z), 1);
        x = '0;       tick(); chk("rnd_a2", int'(z), 0);
        tick();               chk("rnd_a3", int'(z), 0);

        // Rounding: y1=0, y2=3, x_r=0 -> acc=-3 -> -1
        do_reset();
        x = 11'sd3;   tick(); chk("rnd_b0", int'(z), 0);
        x = -11'sd2;  tick(); chk("rnd_b1", int'(z), 3);
        x = '0;       tick(); chk("rnd_b2", int'(z), 0);
        tick();               chk("rnd_b3", int'(z), -1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
